// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters (A, B) sharing one single-port memory.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is fixed A-priority.
module mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_readstart,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_readrdy,
  input  logic              mem_saverdy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  logic we_l;
  logic own_b;
  logic pick_b;
  logic sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARBITER_RR_EN
  logic prefer_b;

  assign pick_b = req_b && (!req_a || prefer_b);

  // Next conflict goes to whichever port lost this grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      prefer_b <= 1'b0;
    end else if (state == S_IDLE && (req_a || req_b)) begin
      prefer_b <= !pick_b;
    end
  end
`else
  assign pick_b = req_b && !req_a;
`endif

  assign sel_we    = pick_b ? we_b    : we_a;
  assign sel_addr  = pick_b ? addr_b  : addr_a;
  assign sel_wdata = pick_b ? wdata_b : wdata_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      we_l          <= 1'b0;
      own_b         <= 1'b0;
      busy          <= 1'b0;
      done_a        <= 1'b0;
      done_b        <= 1'b0;
      rdata_a       <= '0;
      rdata_b       <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wr        <= 1'b0;
      mem_readstart <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_a || req_b) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            own_b    <= pick_b;
            we_l     <= sel_we;
            mem_addr <= sel_addr;
            if (sel_we) begin
              mem_wr    <= 1'b1;
              mem_wdata <= sel_wdata;
            end else begin
              mem_readstart <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          mem_readstart <= 1'b0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (we_l ? mem_saverdy : mem_readrdy) begin
            state     <= S_DONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            if (!we_l && own_b) rdata_b <= mem_rdata;
            if (!we_l && !own_b) rdata_a <= mem_rdata;
            if (own_b) done_b <= 1'b1;
            else done_a <= 1'b1;
          end
        end
        S_DONE: begin
          done_a <= 1'b0;
          done_b <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
